maze_pixel_source: RTL and testbench
====================================

Name: maze_pixel_source

Overview:
- Pixel-colour responder for the VGA timing block. It takes the block's current pixel coordinate (HCOORD/VCOORD) and returns the 12-bit colour CSEL for that pixel.
- The maze is drawn as a 20x15 grid of 32x32-pixel tiles, read from an external synchronous tile-map RAM. The player tile is overlaid on top.
- Runs on the system clock, not the divided pixel clock. CSEL therefore settles well inside each 4-CLK pixel period.
- Also generates a once-per-frame tick for game logic.

Parameters:
- TILE_W, 20, tiles per row (640/32)
- TILE_H, 15, tile rows (480/32)
- C_FLOOR, 12'h222, floor colour
- C_WALL, 12'h00F, wall colour
- C_EXIT, 12'h0F0, exit colour
- C_PLAYER, 12'hF00, player overlay colour

Ports:
- CLK  in  1  system clock; the VGA block divides it by 4 to get its pixel clock
- ARST_L  in  1  asynchronous reset, active low
- HCOORD  in  10  current horizontal pixel coordinate from the VGA block
- VCOORD  in  10  current vertical pixel coordinate from the VGA block
- PLAYER_X  in  5  player tile column, 0..19
- PLAYER_Y  in  4  player tile row, 0..14
- MAP_ADDR  out  9  tile-map RAM read address, = row*20 + col
- MAP_DATA  in  2  tile code; valid 1 CLK after MAP_ADDR is registered
- CSEL  out  12  {R[3:0], G[3:0], B[3:0]} to the VGA block
- FRAME_TICK  out  1  one-CLK pulse at the start of vertical blanking

Behaviour:
- Reset (ARST_L low, asynchronous):
  - MAP_ADDR=0, CSEL=0, FRAME_TICK=0.
  - All pipeline registers cleared; latched player position = (0,0).
- Stage 1 (CLK edge n):
  - Register HCOORD/VCOORD into h1/v1.
  - MAP_ADDR <= VCOORD[8:5]*20 + HCOORD[9:5], computed as (row<<4)+(row<<2)+col in 9 bits, no overflow; maximum is 299.
  - Register the visible flag: vis1 = (HCOORD<640) && (VCOORD<480).
- Stage 2 (edge n+1):
  - MAP_DATA is valid. Register tile2 <= MAP_DATA.
  - Carry h2/v2/vis2 forward.
- Stage 3 (edge n+2): CSEL is registered, with this priority:
  1. If vis2=0, CSEL=0.
  2. Else if (h2[9:5]==px && v2[8:5]==py && h2[4:0] in 4..27 && v2[4:0] in 4..27), CSEL=C_PLAYER.
  3. Else the palette for tile2: 0 -> C_FLOOR, 1 -> C_WALL, 2 -> C_EXIT, 3 -> 12'h000.
- Latency: a coordinate sampled at edge n appears on CSEL after edge n+2. This is 3 CLK edges, strictly less than the 4-CLK pixel period, so CSEL is stable at least 1 CLK before the VGA block's next pixel-clock edge.
- Coordinates outside the visible area (HCOORD 640..800, VCOORD 480..525):
  - MAP_ADDR still computes, and may exceed 299 or alias.
  - The RAM result is ignored because vis2=0.
  - The RAM must tolerate out-of-range addresses.
- Frame tick and player latch:
  - Register vblank_q <= (v1>=480).
  - FRAME_TICK=1 for exactly one CLK when vblank_q goes 0->1.
  - On that same cycle, latch px<=PLAYER_X and py<=PLAYER_Y.
  - PLAYER_X/PLAYER_Y changes at any other time have no effect until the next tick, so there is no tearing mid-frame.
- PLAYER_X>19 or PLAYER_Y>14: latched as given; the overlay never matches a visible tile, so no player is drawn.
- VCOORD wrapping 525->0: no tick. The next tick occurs on the next entry to line 480.
- Reset mid-frame: the pipeline clears. Output recovers 3 CLK after release, with no stale colour. No FRAME_TICK occurs until the next 0->1 vblank transition after release; a reset released during vblank produces no tick for that frame.

Decomposition:
- Shared package maze_pkg:
  - Tile codes TILE_FLOOR=0, TILE_WALL=1, TILE_EXIT=2.
  - H_VISIBLE=640, V_VISIBLE=480, TILE_SHIFT=5, PLAYER_INSET=4.
  - Default colour constants.
- One sub-module, maze_tile_palette: combinational mapping from tile code to 12-bit colour, parameterised by the colours. It is reused later by the minimap block.

Test Plan:
- Reset: hold ARST_L=0 with HCOORD=100 -> CSEL=0, MAP_ADDR=0, FRAME_TICK=0. Release and keep HCOORD=100, VCOORD=40, MAP_DATA=1 -> after 3 CLK, MAP_ADDR=23 and CSEL=12'h00F.
- Address math: (HCOORD,VCOORD)=(639,479) -> MAP_ADDR=299. Then (0,0) -> MAP_ADDR=0. Then (32,32) -> MAP_ADDR=21.
- Blanking:
  - (HCOORD,VCOORD)=(700,100), MAP_DATA=1 -> CSEL=0 after 3 CLK.
  - (HCOORD,VCOORD)=(100,500) -> CSEL=0.
  - (HCOORD,VCOORD)=(639,479), MAP_DATA=2 -> CSEL=12'h0F0.
- Player overlay: PLAYER=(3,2) latched by a tick.
  - (HCOORD,VCOORD)=(100,70) -> CSEL=12'hF00.
  - (HCOORD,VCOORD)=(98,70), inset offset 2 -> CSEL is the tile colour.
  - (HCOORD,VCOORD)=(124,70), offset 28 -> CSEL is the tile colour.
- Tick/latch: sweep VCOORD 478->479->480 -> exactly one FRAME_TICK pulse. Change PLAYER_X 3->4 at VCOORD=200 -> overlay stays at column 3 until the next tick.
- Timing: drive coordinates from a divide-by-4 CLK model over a full 800x525 frame against a reference colour model -> CSEL matches at every pixel-clock rising edge with zero mismatches.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared constants and tile codes for the maze renderer and its companion blocks.
package maze_pkg;

  typedef enum logic [1:0] {
    TILE_FLOOR = 2'd0,
    TILE_WALL  = 2'd1,
    TILE_EXIT  = 2'd2
  } tile_e;

  localparam int          TILE_SHIFT   = 5;
  localparam logic [9:0]  H_VISIBLE    = 10'd640;
  localparam logic [9:0]  V_VISIBLE    = 10'd480;
  localparam logic [4:0]  PLAYER_INSET = 5'd4;

  localparam logic [11:0] C_FLOOR_DEF  = 12'h222;
  localparam logic [11:0] C_WALL_DEF   = 12'h00F;
  localparam logic [11:0] C_EXIT_DEF   = 12'h0F0;
  localparam logic [11:0] C_PLAYER_DEF = 12'hF00;

endpackage

// File: rtl/maze_tile_palette.sv
// Tile code to 12-bit colour lookup; shared with the minimap renderer.
module maze_tile_palette
  import maze_pkg::*;
#(
  parameter logic [11:0] C_FLOOR = C_FLOOR_DEF,
  parameter logic [11:0] C_WALL  = C_WALL_DEF,
  parameter logic [11:0] C_EXIT  = C_EXIT_DEF
) (
  input  logic [1:0]  tile,
  output logic [11:0] colour
);

  always_comb begin
    colour = 12'h000;
    case (tile_e'(tile))
      TILE_FLOOR: colour = C_FLOOR;
      TILE_WALL:  colour = C_WALL;
      TILE_EXIT:  colour = C_EXIT;
      default:    colour = 12'h000;
    endcase
  end

endmodule

// File: rtl/maze_pixel_source.sv
// Three-stage pixel colour pipeline: tile-map address, tile fetch, colour select.
// Also emits the per-frame tick and latches the player position once per frame.
module maze_pixel_source
  import maze_pkg::*;
#(
  parameter int          TILE_W   = 20,
  parameter int          TILE_H   = 15,
  parameter logic [11:0] C_FLOOR  = C_FLOOR_DEF,
  parameter logic [11:0] C_WALL   = C_WALL_DEF,
  parameter logic [11:0] C_EXIT   = C_EXIT_DEF,
  parameter logic [11:0] C_PLAYER = C_PLAYER_DEF
) (
  input  logic        CLK,
  input  logic        ARST_L,
  input  logic [9:0]  HCOORD,
  input  logic [9:0]  VCOORD,
  input  logic [4:0]  PLAYER_X,
  input  logic [3:0]  PLAYER_Y,
  output logic [8:0]  MAP_ADDR,
  input  logic [1:0]  MAP_DATA,
  output logic [11:0] CSEL,
  output logic        FRAME_TICK
);

  localparam logic [9:0] H_LIMIT = 10'(TILE_W << TILE_SHIFT);
  localparam logic [9:0] V_LIMIT = 10'(TILE_H << TILE_SHIFT);

  logic [9:0]  h1, v1, h2;
  logic [8:0]  v2;
  logic        vis1, vis2, val1;
  logic [1:0]  tile2;
  logic        vblank_q;
  logic [4:0]  px;
  logic [3:0]  py;

  logic [8:0]  row9, addr_d;
  logic        vis_d, vblank_d, tick_d, player_hit;
  logic [11:0] tile_colour, csel_d;

  // row*20 + col as shift-adds; worst case 15*20+31 = 331 still fits 9 bits
  assign row9   = {5'd0, VCOORD[8:5]};
  assign addr_d = (row9 << 4) + (row9 << 2) + {4'd0, HCOORD[9:5]};
  assign vis_d  = (HCOORD < H_LIMIT) && (VCOORD < V_LIMIT);

  assign vblank_d = (v1 >= V_VISIBLE);
  assign tick_d   = val1 && vblank_d && !vblank_q;

  // ~PLAYER_INSET is 31-4 = 27, the mirrored inset on the far side of the tile
  assign player_hit = (h2[9:5] == px) && (v2[8:5] == py) &&
                      (h2[4:0] >= PLAYER_INSET) && (h2[4:0] <= ~PLAYER_INSET) &&
                      (v2[4:0] >= PLAYER_INSET) && (v2[4:0] <= ~PLAYER_INSET);

  maze_tile_palette #(
    .C_FLOOR (C_FLOOR),
    .C_WALL  (C_WALL),
    .C_EXIT  (C_EXIT)
  ) u_palette (
    .tile   (tile2),
    .colour (tile_colour)
  );

  always_comb begin
    csel_d = tile_colour;
    if (!vis2)           csel_d = 12'h000;
    else if (player_hit) csel_d = C_PLAYER;
  end

  // vblank_q resets high and only tracks once val1 is set, so a reset released
  // inside blanking cannot fake a 0->1 transition on the first real sample.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      h1         <= '0;
      v1         <= '0;
      vis1       <= 1'b0;
      val1       <= 1'b0;
      MAP_ADDR   <= '0;
      h2         <= '0;
      v2         <= '0;
      vis2       <= 1'b0;
      tile2      <= '0;
      CSEL       <= '0;
      vblank_q   <= 1'b1;
      FRAME_TICK <= 1'b0;
      px         <= '0;
      py         <= '0;
    end else begin
      h1         <= HCOORD;
      v1         <= VCOORD;
      vis1       <= vis_d;
      val1       <= 1'b1;
      MAP_ADDR   <= addr_d;
      h2         <= h1;
      v2         <= v1[8:0];
      vis2       <= vis1;
      tile2      <= MAP_DATA;
      CSEL       <= csel_d;
      FRAME_TICK <= tick_d;
      if (val1) vblank_q <= vblank_d;
      if (tick_d) begin
        px <= PLAYER_X;
        py <= PLAYER_Y;
      end
    end
  end

endmodule

// File: tb/tb_maze_pixel_source.sv
// Scoreboard bench for maze_pixel_source against a per-pixel reference colour model.
module tb_maze_pixel_source;

  logic        CLK = 1'b0;
  logic        ARST_L = 1'b1;
  logic [9:0]  HCOORD = '0;
  logic [9:0]  VCOORD = '0;
  logic [4:0]  PLAYER_X = '0;
  logic [3:0]  PLAYER_Y = '0;
  logic [8:0]  MAP_ADDR;
  logic [1:0]  MAP_DATA;
  logic [11:0] CSEL;
  logic        FRAME_TICK;

  maze_pixel_source dut (
    .CLK        (CLK),
    .ARST_L     (ARST_L),
    .HCOORD     (HCOORD),
    .VCOORD     (VCOORD),
    .PLAYER_X   (PLAYER_X),
    .PLAYER_Y   (PLAYER_Y),
    .MAP_ADDR   (MAP_ADDR),
    .MAP_DATA   (MAP_DATA),
    .CSEL       (CSEL),
    .FRAME_TICK (FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  // Tile-map RAM: address register lives in the DUT, data read straight out.
  logic [1:0] mem [512];
  assign MAP_DATA = mem[MAP_ADDR];

  typedef struct {
    int          due;
    logic [11:0] val;
  } exp_t;

  exp_t csel_q[$];
  exp_t addr_q[$];
  int   tick_q[$];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;

  // reference model state
  int m_px = 0, m_py = 0;
  bit m_prev_known = 0;
  int m_prev_v = 0;
  bit m_latch_pend = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_colour(input int h, input int v);
    int t;
    if (h >= 640 || v >= 480) return 12'h000;
    if (h / 32 == m_px && v / 32 == m_py &&
        h % 32 >= 4 && h % 32 <= 27 && v % 32 >= 4 && v % 32 <= 27)
      return 12'hF00;
    t = int'(mem[(v / 32) * 20 + h / 32]);
    case (t)
      0:       return 12'h222;
      1:       return 12'h00F;
      2:       return 12'h0F0;
      default: return 12'h000;
    endcase
  endfunction

  task automatic drive(input int h, input int v);
    exp_t e;
    @(negedge CLK);
    HCOORD = 10'(h);
    VCOORD = 10'(v);
    if (m_latch_pend) begin
      m_px = int'(PLAYER_X);
      m_py = int'(PLAYER_Y);
      m_latch_pend = 0;
    end
    e.due = cyc + 1;
    e.val = 12'(((v / 32) % 16) * 20 + h / 32);
    addr_q.push_back(e);
    e.due = cyc + 3;
    e.val = ref_colour(h, v);
    csel_q.push_back(e);
    if (m_prev_known && m_prev_v < 480 && v >= 480) begin
      tick_q.push_back(cyc + 2);
      m_latch_pend = 1;
    end
    m_prev_known = 1;
    m_prev_v = v;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    #1;
    ARST_L = 1'b0;
    csel_q.delete();
    addr_q.delete();
    tick_q.delete();
    m_px = 0; m_py = 0;
    m_prev_known = 0;
    m_latch_pend = 0;
    repeat (cycles) @(posedge CLK);
    #1;
    check("rst_csel", CSEL, 12'h000);
    check("rst_addr", {3'd0, MAP_ADDR}, 12'h000);
    check("rst_tick", {11'd0, FRAME_TICK}, 12'h000);
    ARST_L = 1'b1;
    mon_en = 1;
  endtask

  // blank two samples so no visible sample is mid-fetch when the map changes
  task automatic quiesce();
    repeat (2) drive(700, 500);
  endtask

  task automatic fill_mem(input int val);
    quiesce();
    foreach (mem[i]) mem[i] = 2'(val);
  endtask

  task automatic random_mem();
    quiesce();
    foreach (mem[i]) mem[i] = 2'($urandom_range(0, 3));
  endtask

  exp_t me;
  bit   exp_tick;
  always @(negedge CLK) begin
    if (mon_en && ARST_L) begin
      if (addr_q.size() != 0 && addr_q[0].due == cyc) begin
        me = addr_q.pop_front();
        check("map_addr", {3'd0, MAP_ADDR}, me.val);
      end
      if (csel_q.size() != 0 && csel_q[0].due == cyc) begin
        me = csel_q.pop_front();
        check("csel", CSEL, me.val);
      end
      exp_tick = (tick_q.size() != 0 && tick_q[0] == cyc);
      if (exp_tick) void'(tick_q.pop_front());
      check("frame_tick", {11'd0, FRAME_TICK}, {11'd0, exp_tick});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mem[i]) mem[i] = 2'd1;
    HCOORD = 10'd100;
    VCOORD = 10'd40;
    do_reset(3);

    // first transaction after release: tile (3,1), wall
    repeat (3) drive(100, 40);

    // address corners
    drive(639, 479);
    drive(0, 0);
    drive(32, 32);

    // blanking suppresses the tile colour
    drive(700, 100);
    drive(100, 500);
    fill_mem(2);
    drive(639, 479);

    // player overlay latched by a vblank entry
    fill_mem(0);
    PLAYER_X = 5'd3;
    PLAYER_Y = 4'd2;
    drive(0, 478);
    drive(0, 479);
    drive(0, 480);
    drive(0, 481);
    drive(100, 70);
    drive(98, 70);
    drive(124, 70);
    drive(123, 70);

    // a mid-frame change must not move the overlay until the next tick
    drive(100, 200);
    PLAYER_X = 5'd4;
    drive(100, 200);
    drive(100, 70);
    drive(132, 70);
    drive(0, 479);
    drive(0, 480);
    drive(100, 70);
    drive(132, 70);

    // reset mid-frame, then reset inside vblank
    drive(132, 70);
    do_reset(2);
    drive(132, 70);
    drive(132, 70);
    check("no_stale", CSEL, 12'h000);
    drive(132, 70);
    drive(0, 490);
    do_reset(2);
    drive(0, 495);
    drive(0, 500);
    drive(0, 0);
    drive(0, 479);
    drive(0, 480);

    // randomized samples with a random map and occasional player moves
    random_mem();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        PLAYER_X = 5'($urandom_range(0, 31));
        PLAYER_Y = 4'($urandom_range(0, 15));
      end
      drive($urandom_range(0, 799), $urandom_range(0, 524));
    end

    // compressed frames: every line, random column
    for (int f = 0; f < 3; f++) begin
      PLAYER_X = 5'($urandom_range(0, 21));
      PLAYER_Y = 4'($urandom_range(0, 15));
      for (int v = 0; v < 525; v++) drive($urandom_range(0, 799), v);
    end

    // pixel-clock paced lines: each pixel held for 4 CLK
    PLAYER_X = 5'd2;
    PLAYER_Y = 4'd1;
    drive(0, 479);
    drive(0, 480);
    begin
      int lines [5];
      lines = '{0, 31, 36, 70, 479};
      foreach (lines[l])
        for (int h = 0; h < 800; h++)
          repeat (4) drive(h, lines[l]);
    end

    repeat (4) drive(700, 500);
    repeat (4) @(negedge CLK);
    check("drain", 12'(csel_q.size() + addr_q.size() + tick_q.size()), 12'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
